// File: rtl/axi_sram_slave_if.sv
// axi_if: AXI4-Lite link bundle (single outstanding, no IDs, no bursts).
//
// Parameters:
//   ADDR_W - address width
//   DATA_W - data width (byte strobes are fixed at 4, i.e. 32-bit data)
//
// Modports:
//   Master - drives AR/AW/W valid+payload and R/B ready
//   Slave  - drives AR/AW/W ready and R/B valid+payload
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_ready;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_ready;

    logic              aw_valid;
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_ready;

    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [3:0]        w_strb;
    logic              w_ready;

    logic              b_valid;
    logic [1:0]        b_resp;
    logic              b_ready;

    modport Master (
        output ar_valid, ar_addr,
        input  ar_ready,
        input  r_valid, r_data, r_resp,
        output r_ready,
        output aw_valid, aw_addr,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready
    );

    modport Slave (
        input  ar_valid, ar_addr,
        output ar_ready,
        output r_valid, r_data, r_resp,
        input  r_ready,
        input  aw_valid, aw_addr,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite responder backed by a word-addressed memory.
//
// Read and write channels run independent FSMs with a programmable response
// delay. Accesses outside [BASE, BASE + 4*DEPTH) answer SLVERR; reads of
// such addresses return zero and writes are dropped.
//
// Parameters:
//   ADDR_W - address width (must match the axi_if instance)
//   DATA_W - data width, 32 only
//   BASE   - byte address of word 0
//   DEPTH  - number of 32-bit words, power of two
//   LAT    - fixed extra response cycles, 0..15
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-high; aborts any transaction in flight
//   s      - axi_if.Slave link
//
// Build option:
//   AXI_SRAM_RAND_DELAY_EN - when defined, each transaction's delay is
//   LAT + lfsr[3:0] from a free-running 16-bit Fibonacci LFSR (taps
//   16,14,13,11, seed 16'hACE1). When undefined the delay is exactly LAT.
module axi_sram_slave #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
    parameter int                DEPTH  = 4096,
    parameter int                LAT    = 1
) (
    input  logic  clock,
    input  logic  reset,
    axi_if.Slave  s
);

    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   SPAN        = (ADDR_W + 1)'(4 * DEPTH);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef logic [4:0] dly_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Response delay source
    // ------------------------------------------------------------------
    dly_t delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign delay = dly_t'(LAT) + {1'b0, lfsr[3:0]};
`else
    assign delay = dly_t'(LAT);
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t         r_state, r_state_nx;
    dly_t              r_cnt, r_cnt_nx;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_off;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_hit;
    logic              rd_take;
    logic              rd_sample;

    // In R_IDLE the sample may happen in the handshake cycle itself (zero
    // delay), so the live bus address is used there instead of the latch.
    assign rd_addr = (r_state == R_IDLE) ? s.ar_addr : ar_addr_q;
    assign rd_off  = rd_addr - BASE;
    // Unsigned wrap makes addresses below BASE look huge, so one compare
    // covers both bounds.
    assign rd_hit  = {1'b0, rd_off} < SPAN;
    assign rd_idx  = rd_off[IDX_W+1:2];

    always_comb begin
        r_state_nx = r_state;
        r_cnt_nx   = r_cnt;
        rd_take    = 1'b0;
        rd_sample  = 1'b0;
        s.ar_ready = 1'b0;
        s.r_valid  = 1'b0;

        case (r_state)
            R_IDLE: begin
                s.ar_ready = !reset;
                if (s.ar_valid && !reset) begin
                    rd_take = 1'b1;
                    if (delay == '0) begin
                        rd_sample  = 1'b1;
                        r_state_nx = R_RESP;
                    end else begin
                        r_cnt_nx   = delay;
                        r_state_nx = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // Counter holds remaining wait cycles including this one.
                if (r_cnt <= 5'd1) begin
                    rd_sample  = 1'b1;
                    r_state_nx = R_RESP;
                end else begin
                    r_cnt_nx = r_cnt - 5'd1;
                end
            end
            R_RESP: begin
                s.r_valid = 1'b1;
                if (s.r_ready) begin
                    r_state_nx = R_IDLE;
                end
            end
            default: begin
                r_state_nx = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            s.r_data  <= '0;
            s.r_resp  <= RESP_OKAY;
        end else begin
            r_state <= r_state_nx;
            r_cnt   <= r_cnt_nx;
            if (rd_take) begin
                ar_addr_q <= s.ar_addr;
            end
            if (rd_sample) begin
                s.r_data <= rd_hit ? mem[rd_idx] : '0;
                s.r_resp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t         w_state, w_state_nx;
    dly_t              w_cnt, w_cnt_nx;
    logic              aw_done, w_done;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [3:0]        w_strb_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_strb;
    logic [ADDR_W-1:0] wr_off;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_hit;
    logic              aw_take, w_take;
    logic              wr_commit;
    logic              b_take;

    // Effective payload: the latched copy once captured, otherwise the bus.
    // The flags stay set through W_WAIT/W_RESP, so the same mux serves both
    // the zero-delay commit in W_IDLE and the delayed commit in W_WAIT.
    assign wr_addr = aw_done ? aw_addr_q : s.aw_addr;
    assign wr_data = w_done  ? w_data_q  : s.w_data;
    assign wr_strb = w_done  ? w_strb_q  : s.w_strb;
    assign wr_off  = wr_addr - BASE;
    assign wr_hit  = {1'b0, wr_off} < SPAN;
    assign wr_idx  = wr_off[IDX_W+1:2];

    always_comb begin
        w_state_nx = w_state;
        w_cnt_nx   = w_cnt;
        aw_take    = 1'b0;
        w_take     = 1'b0;
        wr_commit  = 1'b0;
        b_take     = 1'b0;
        s.aw_ready = 1'b0;
        s.w_ready  = 1'b0;
        s.b_valid  = 1'b0;

        case (w_state)
            W_IDLE: begin
                s.aw_ready = !reset && !aw_done;
                s.w_ready  = !reset && !w_done;
                aw_take    = s.aw_ready && s.aw_valid;
                w_take     = s.w_ready && s.w_valid;
                if ((aw_done || aw_take) && (w_done || w_take)) begin
                    if (delay == '0) begin
                        wr_commit  = 1'b1;
                        w_state_nx = W_RESP;
                    end else begin
                        w_cnt_nx   = delay;
                        w_state_nx = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt <= 5'd1) begin
                    wr_commit  = 1'b1;
                    w_state_nx = W_RESP;
                end else begin
                    w_cnt_nx = w_cnt - 5'd1;
                end
            end
            W_RESP: begin
                s.b_valid = 1'b1;
                if (s.b_ready) begin
                    b_take     = 1'b1;
                    w_state_nx = W_IDLE;
                end
            end
            default: begin
                w_state_nx = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s.b_resp  <= RESP_OKAY;
        end else begin
            w_state <= w_state_nx;
            w_cnt   <= w_cnt_nx;
            if (aw_take) begin
                aw_addr_q <= s.aw_addr;
                aw_done   <= 1'b1;
            end
            if (w_take) begin
                w_data_q <= s.w_data;
                w_strb_q <= s.w_strb;
                w_done   <= 1'b1;
            end
            if (b_take) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (wr_commit) begin
                s.b_resp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Memory array is deliberately not reset. Reset forces the write FSM out
    // of W_WAIT asynchronously, so an aborted write never reaches commit.
    always_ff @(posedge clock) begin
        if (wr_commit && wr_hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: self-checking bench for axi_sram_slave.
// Directed scenarios followed by randomized traffic checked against an
// associative-array memory model. Latency is exact (LAT) in the default
// build and bounded to LAT..LAT+15 when AXI_SRAM_RAND_DELAY_EN is defined.
module tb_axi_sram_slave;

    localparam int          LAT   = 1;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mdl [int unsigned];

    axi_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_sram_slave #(
        .ADDR_W (32),
        .DATA_W (32),
        .BASE   (BASE),
        .DEPTH  (DEPTH),
        .LAT    (LAT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .s     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned la;
        longint unsigned lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + 4 * DEPTH);
    endfunction

    function automatic int unsigned model_word(input logic [31:0] a);
        return (a - BASE) >> 2;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] strb);
        logic [31:0] cur;
        int unsigned w;
        if (!model_hit(a)) return;
        w   = model_word(a);
        cur = mdl.exists(w) ? mdl[w] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        mdl[w] = cur;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'h0;
        return mdl.exists(model_word(a)) ? mdl[model_word(a)] : 32'h0;
    endfunction

    function automatic bit delay_ok(input int n);
`ifdef AXI_SRAM_RAND_DELAY_EN
        return (n >= LAT) && (n <= LAT + 15);
`else
        return n == LAT;
`endif
    endfunction

    // ---------------- bus drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // n = cycles from the AR handshake edge until r_valid is seen, i.e. delay.
    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int n, output bit stable);
        int guard;
        guard  = 0;
        stable = 1'b1;
        bus.ar_addr  = addr;
        bus.ar_valid = 1'b1;
        while (!bus.ar_ready && guard < 100) begin
            next_cycle();
            guard++;
        end
        next_cycle();
        bus.ar_valid = 1'b0;
        n = 0;
        while (!bus.r_valid && n < 100) begin
            next_cycle();
            n++;
        end
        data = bus.r_data;
        resp = bus.r_resp;
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            if (!bus.r_valid || bus.r_data !== data || bus.r_resp !== resp || bus.ar_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.r_ready = 1'b1;
        next_cycle();
        bus.r_ready = 1'b0;
    endtask

    // mode 0: AW and W together, 1: W first, 2: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int mode, input int hold,
                            output logic [1:0] resp, output int n, output bit ok);
        int guard;
        guard = 0;
        ok    = 1'b1;
        while (!(bus.aw_ready && bus.w_ready) && guard < 100) begin
            next_cycle();
            guard++;
        end
        bus.aw_addr = addr;
        bus.w_data  = data;
        bus.w_strb  = strb;
        case (mode)
            0: begin
                bus.aw_valid = 1'b1;
                bus.w_valid  = 1'b1;
                next_cycle();
                bus.aw_valid = 1'b0;
                bus.w_valid  = 1'b0;
            end
            1: begin
                bus.w_valid = 1'b1;
                next_cycle();
                bus.w_valid = 1'b0;
                if (bus.w_ready !== 1'b0 || bus.aw_ready !== 1'b1 || bus.b_valid !== 1'b0) ok = 1'b0;
                bus.aw_valid = 1'b1;
                next_cycle();
                bus.aw_valid = 1'b0;
            end
            default: begin
                bus.aw_valid = 1'b1;
                next_cycle();
                bus.aw_valid = 1'b0;
                if (bus.aw_ready !== 1'b0 || bus.w_ready !== 1'b1 || bus.b_valid !== 1'b0) ok = 1'b0;
                bus.w_valid = 1'b1;
                next_cycle();
                bus.w_valid = 1'b0;
            end
        endcase
        n = 0;
        while (!bus.b_valid && n < 100) begin
            next_cycle();
            n++;
        end
        resp = bus.b_resp;
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            if (!bus.b_valid || bus.b_resp !== resp || bus.aw_ready !== 1'b0 || bus.w_ready !== 1'b0)
                ok = 1'b0;
        end
        bus.b_ready = 1'b1;
        next_cycle();
        bus.b_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if ({bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_handshake: got %b expected 00000",
                     {bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid});
        end
        compared++;
        if ({bus.r_data, bus.r_resp, bus.b_resp} !== 36'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0", {bus.r_data, bus.r_resp, bus.b_resp});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        compared++;
        if ({bus.ar_ready, bus.aw_ready, bus.w_ready} !== 3'b111) begin
            mismatched++;
            $display("FAIL release_readies: got %b expected 111", {bus.ar_ready, bus.aw_ready, bus.w_ready});
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        bit          ok;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, n, ok);
        compared++;
        if (resp !== 2'b00) begin mismatched++; $display("FAIL wr_resp: got %b expected 00", resp); end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL wr_latency: got %0d expected %0d", n, LAT); end
        do_read(32'h8000_0010, 0, d, resp, n, ok);
        compared++;
        if (d !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL rd_data: got %h expected deadbeef", d); end
        compared++;
        if (resp !== 2'b00) begin mismatched++; $display("FAIL rd_resp: got %b expected 00", resp); end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL rd_latency: got %0d expected %0d", n, LAT); end
    endtask

    task automatic test_strobe_order();
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        bit          ok;
        do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 1, 0, resp, n, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL w_first_capture: got %b expected 1", ok); end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL w_first_latency: got %0d expected %0d", n, LAT); end
        do_read(32'h8000_0010, 0, d, resp, n, ok);
        compared++;
        if (d !== 32'hDE22_BE44) begin mismatched++; $display("FAIL strb_merge: got %h expected de22be44", d); end
        do_write(32'h8000_0010, 32'hCAFE_0000, 4'b1100, 2, 0, resp, n, ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL aw_first_capture: got %b expected 1", ok); end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL aw_first_latency: got %0d expected %0d", n, LAT); end
        do_read(32'h8000_0012, 0, d, resp, n, ok);
        compared++;
        if (d !== 32'hCAFE_BE44) begin mismatched++; $display("FAIL strb_merge_hi: got %h expected cafebe44", d); end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        bit          ok;
        do_write(32'h8000_0000, 32'hA5A5_0001, 4'hF, 0, 0, resp, n, ok);
        do_write(32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 0, 0, resp, n, ok);
        compared++;
        if (resp !== 2'b00) begin mismatched++; $display("FAIL last_word_wr_resp: got %b expected 00", resp); end
        do_read(32'h8000_3FFC, 0, d, resp, n, ok);
        compared++;
        if ({resp, d} !== {2'b00, 32'h0BAD_F00D}) begin
            mismatched++; $display("FAIL last_word_rd: got %b/%h expected 00/0badf00d", resp, d);
        end
        do_read(32'h7FFF_FFFC, 0, d, resp, n, ok);
        compared++;
        if ({resp, d} !== {2'b10, 32'h0}) begin
            mismatched++; $display("FAIL below_base_rd: got %b/%h expected 10/00000000", resp, d);
        end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL oor_rd_latency: got %0d expected %0d", n, LAT); end
        do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, n, ok);
        compared++;
        if (resp !== 2'b10) begin mismatched++; $display("FAIL above_top_wr_resp: got %b expected 10", resp); end
        do_read(32'h8000_4000, 0, d, resp, n, ok);
        compared++;
        if ({resp, d} !== {2'b10, 32'h0}) begin
            mismatched++; $display("FAIL above_top_rd: got %b/%h expected 10/00000000", resp, d);
        end
        do_read(32'h8000_0000, 0, d, resp, n, ok);
        compared++;
        if ({resp, d} !== {2'b00, 32'hA5A5_0001}) begin
            mismatched++; $display("FAIL oor_wr_no_commit: got %b/%h expected 00/a5a50001", resp, d);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        bit          st;
        do_read(32'h8000_0010, 5, d, resp, n, st);
        compared++;
        if (st !== 1'b1) begin mismatched++; $display("FAIL r_hold_stable: got %b expected 1", st); end
        compared++;
        if (d !== 32'hCAFE_BE44) begin mismatched++; $display("FAIL r_hold_data: got %h expected cafebe44", d); end
        do_write(32'h8000_0020, 32'h1234_5678, 4'hF, 0, 4, resp, n, st);
        compared++;
        if (st !== 1'b1) begin mismatched++; $display("FAIL b_hold_stable: got %b expected 1", st); end
    endtask

    task automatic test_reset_abort();
        logic [1:0]  resp;
        logic [31:0] d;
        int          n;
        bit          ok;
        bit          seen;
        // read aborted in R_WAIT
        bus.ar_addr  = 32'h8000_0010;
        bus.ar_valid = 1'b1;
        next_cycle();
        bus.ar_valid = 1'b0;
        rst  = 1'b1;
        seen = 1'b0;
        #1;
        compared++;
        if ({bus.ar_ready, bus.r_valid, bus.r_data} !== 34'h0) begin
            mismatched++; $display("FAIL abort_rd_in_reset: got %h expected 0", {bus.ar_ready, bus.r_valid, bus.r_data});
        end
        repeat (3) begin next_cycle(); if (bus.r_valid) seen = 1'b1; end
        rst = 1'b0;
        #1;
        compared++;
        if (bus.ar_ready !== 1'b1) begin mismatched++; $display("FAIL abort_rd_ready: got %b expected 1", bus.ar_ready); end
        repeat (5) begin next_cycle(); if (bus.r_valid) seen = 1'b1; end
        compared++;
        if (seen !== 1'b0) begin mismatched++; $display("FAIL abort_rd_no_resp: got %b expected 0", seen); end
        do_read(32'h8000_0010, 0, d, resp, n, ok);
        compared++;
        if ({resp, d} !== {2'b00, 32'hCAFE_BE44}) begin
            mismatched++; $display("FAIL post_abort_rd: got %b/%h expected 00/cafebe44", resp, d);
        end
        compared++;
        if (!delay_ok(n)) begin mismatched++; $display("FAIL post_abort_latency: got %0d expected %0d", n, LAT); end
        // write aborted in W_WAIT
        bus.aw_addr  = 32'h8000_0020;
        bus.w_data   = 32'hFFFF_FFFF;
        bus.w_strb   = 4'hF;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        next_cycle();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        rst  = 1'b1;
        seen = 1'b0;
        repeat (3) begin next_cycle(); if (bus.b_valid) seen = 1'b1; end
        rst = 1'b0;
        #1;
        compared++;
        if ({bus.aw_ready, bus.w_ready} !== 2'b11) begin
            mismatched++; $display("FAIL abort_wr_flags: got %b expected 11", {bus.aw_ready, bus.w_ready});
        end
        repeat (4) begin next_cycle(); if (bus.b_valid) seen = 1'b1; end
        compared++;
        if (seen !== 1'b0) begin mismatched++; $display("FAIL abort_wr_no_resp: got %b expected 0", seen); end
        do_read(32'h8000_0020, 0, d, resp, n, ok);
        compared++;
        if (d !== 32'h1234_5678) begin mismatched++; $display("FAIL abort_wr_lost: got %h expected 12345678", d); end
    endtask

    task automatic test_random();
        logic [31:0] win;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [1:0]  resp;
        logic [1:0]  exp_r;
        logic [3:0]  strb;
        int          n;
        bit          ok;
        win = BASE + 32'h100;
        for (int i = 0; i < 16; i++) begin
            a = win + 32'(4 * i);
            d = $urandom;
            do_write(a, d, 4'hF, 0, 0, resp, n, ok);
            model_write(a, d, 4'hF);
        end
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = win + 32'(4 * $urandom_range(0, 15));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE - 32'(4 * $urandom_range(1, 1000));
                    2:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
                    default: a = 32'h0000_0100;
                endcase
            end
            a[1:0] = 2'($urandom_range(0, 3));
            exp_r  = model_hit(a) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 0) begin
                d    = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(a, d, strb, $urandom_range(0, 2), $urandom_range(0, 2), resp, n, ok);
                model_write(a, d, strb);
                compared++;
                if (resp !== exp_r) begin mismatched++; $display("FAIL rnd_wr_resp[%0d]: got %b expected %b addr %h", k, resp, exp_r, a); end
                compared++;
                if (!delay_ok(n) || !ok) begin mismatched++; $display("FAIL rnd_wr_timing[%0d]: got delay %0d ok %b expected %0d/1", k, n, ok, LAT); end
            end else begin
                exp_d = model_read(a);
                do_read(a, $urandom_range(0, 2), d, resp, n, ok);
                compared++;
                if ({resp, d} !== {exp_r, exp_d}) begin
                    mismatched++; $display("FAIL rnd_rd[%0d]: got %b/%h expected %b/%h addr %h", k, resp, d, exp_r, exp_d, a);
                end
                compared++;
                if (!delay_ok(n) || !ok) begin mismatched++; $display("FAIL rnd_rd_timing[%0d]: got delay %0d ok %b expected %0d/1", k, n, ok, LAT); end
            end
        end
    endtask

    initial begin
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        bus.r_ready  = 1'b0;
        bus.aw_valid = 1'b0;
        bus.aw_addr  = '0;
        bus.w_valid  = 1'b0;
        bus.w_data   = '0;
        bus.w_strb   = '0;
        bus.b_ready  = 1'b0;
        test_reset();
        test_write_read();
        test_strobe_order();
        test_out_of_range();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
